// File: rtl/rms_pkg.sv
// Shared types and widths for the RMS calculator: reader FSM states and
// accumulator sizing used by both the reader and the square-root stage.
package rms_pkg;

   localparam int unsigned RMS_WIDTH = 32;
   localparam int unsigned RMS_LOG2N = 6;

   function automatic int unsigned ACC_W(input int unsigned width, input int unsigned log2n);
      return 2 * width + log2n;
   endfunction

   localparam int unsigned RMS_SQ_W  = 2 * RMS_WIDTH;
   localparam int unsigned RMS_ACC_W = ACC_W(RMS_WIDTH, RMS_LOG2N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rms_state_e;

endpackage

// File: rtl/rms_square.sv
// Registered signed squarer: one-cycle latency, valid travels alongside data.
module rms_square
   import rms_pkg::*;
#(
   parameter int unsigned WIDTH = RMS_WIDTH
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clr,
   input  logic                 i_valid,
   input  logic [WIDTH-1:0]     i_data,
   output logic [2*WIDTH-1:0]   o_sq,
   output logic                 o_valid
);

   localparam int unsigned SQ_W = 2 * WIDTH;

   logic signed [WIDTH-1:0] w_data;
   logic signed [SQ_W-1:0]  w_prod;
   logic [SQ_W-1:0]         r_sq;
   logic                    r_valid;

   // Sign-extend before multiplying so the most negative input squares correctly.
   assign w_data = $signed(i_data);
   assign w_prod = SQ_W'(w_data) * SQ_W'(w_data);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_sq    <= '0;
         r_valid <= 1'b0;
      end else if (i_clr) begin
         r_sq    <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= i_valid;
         if (i_valid) r_sq <= w_prod;
      end
   end

   assign o_sq    = r_sq;
   assign o_valid = r_valid;

endmodule

// File: rtl/rms_sample_reader.sv
// FIFO read-side consumer: pops samples, squares and accumulates a window of
// 2^LOG2N squares, then publishes the floored mean square.
module rms_sample_reader
   import rms_pkg::*;
#(
   parameter int unsigned WIDTH = RMS_WIDTH,
   parameter int unsigned LOG2N = RMS_LOG2N
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_clear,
   input  logic                 i_fifo_empty,
   input  logic [WIDTH-1:0]     i_fifo_data,
   output logic                 o_fifo_rd,
   output logic [2*WIDTH-1:0]   o_msq,
   output logic                 o_msq_valid,
   output logic                 o_busy
);

   localparam int unsigned AW    = ACC_W(WIDTH, LOG2N);
   localparam int unsigned CNT_W = LOG2N + 1;
   localparam int unsigned SQ_W  = 2 * WIDTH;
   localparam logic [CNT_W-1:0] LAST_RD = CNT_W'((1 << LOG2N) - 1);

   rms_state_e        r_state;
   rms_state_e        w_state_nxt;
   logic              w_fifo_rd;
   logic              w_done_entry;
   logic [CNT_W-1:0]  r_rd_cnt;
   logic              r_rd_q;
   logic [SQ_W-1:0]   w_sq;
   logic              w_sq_v;
   logic [AW-1:0]     r_acc;
   logic [SQ_W-1:0]   r_msq;
   logic              r_msq_valid;
   logic              r_busy;

   rms_square #(.WIDTH(WIDTH)) u_square (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (i_clear),
      .i_valid (r_rd_q),
      .i_data  (i_fifo_data),
      .o_sq    (w_sq),
      .o_valid (w_sq_v)
   );

   // Next-state and read request; clear overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      w_fifo_rd   = 1'b0;
      case (r_state)
         IDLE:    if (i_start) w_state_nxt = RUN;
         RUN: begin
            w_fifo_rd = !i_fifo_empty;
            if (w_fifo_rd && (r_rd_cnt == LAST_RD)) w_state_nxt = DRAIN;
         end
         DRAIN:   if (!r_rd_q && !w_sq_v) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (i_clear) w_state_nxt = IDLE;
   end

   assign w_done_entry = (r_state == DRAIN) && (w_state_nxt == DONE);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != IDLE);
      end
   end

   // Read counter, read pipeline stage, accumulator and result register.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_rd_cnt    <= '0;
         r_rd_q      <= 1'b0;
         r_acc       <= '0;
         r_msq       <= '0;
         r_msq_valid <= 1'b0;
      end else if (i_clear) begin
         r_rd_cnt    <= '0;
         r_rd_q      <= 1'b0;
         r_acc       <= '0;
         r_msq_valid <= 1'b0;
      end else begin
         r_rd_q      <= w_fifo_rd;
         r_msq_valid <= w_done_entry;
         if (w_fifo_rd)
            r_rd_cnt <= r_rd_cnt + CNT_W'(1);
         else if (r_state == DONE)
            r_rd_cnt <= '0;
         if (r_state == DONE)
            r_acc <= '0;
         else if (w_sq_v)
            r_acc <= r_acc + AW'(w_sq);
         if (w_done_entry)
            r_msq <= SQ_W'(r_acc >> LOG2N);
      end
   end

   assign o_fifo_rd   = w_fifo_rd;
   assign o_msq       = r_msq;
   assign o_msq_valid = r_msq_valid;
   assign o_busy      = r_busy;

endmodule

// File: doc/rms_sample_reader.md
# rms_sample_reader

Read-side consumer for the RMS calculator's sample FIFO. Pops signed samples whenever the FIFO is non-empty, squares them in a pipelined stage, and accumulates a window of 2^LOG2N squares. At window end it emits the truncated mean square to the downstream square-root stage. It is the only agent driving the FIFO's `read` input.

## Interface
- `WIDTH`, 32: sample width, signed two's complement; equals the FIFO data width.
- `LOG2N`, 6: log2 of window length N (N = 2^LOG2N samples per result).
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low; clears all state and outputs.
- `start` in 1: one-cycle pulse that begins a window; ignored while `busy`.
- `clear` in 1: synchronous abort; takes priority over `start` and datapath activity.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_data` in WIDTH: FIFO registered read data, valid the cycle after a read is accepted.
- `fifo_rd` out 1: FIFO read request; combinational.
- `msq` out 2*WIDTH: mean square of the last completed window; holds until the next result.
- `msq_valid` out 1: one-cycle pulse when `msq` updates.
- `busy` out 1: high in RUN, DRAIN and DONE.

## Operation
- States: IDLE → RUN on `start`. RUN → DRAIN when the Nth read is issued. DRAIN → DONE when the pipeline is empty. DONE → IDLE after one cycle.
- `fifo_rd` = (state==RUN) && !`fifo_empty`. The block never reads when empty, so the FIFO's write+read+empty case never performs a read.
- Read counter: LOG2N+1 bits, counts issued reads. The Nth read moves to DRAIN, so no further reads are issued.
- Pipeline:
  - `rd_q` <= `fifo_rd`.
  - Square stage: `sq_q` <= `fifo_data`*`fifo_data` (signed × signed, 2*WIDTH-bit result, non-negative); `sq_v` <= `rd_q`.
  - Accumulate stage: when `sq_v`, `acc` += `sq_q`.
- `acc` width is 2*WIDTH+LOG2N. It cannot overflow; the max square is 2^(2*WIDTH-2).
- DRAIN exits when `rd_q`==0 and `sq_v`==0.
- DONE: `msq` <= `acc` >> LOG2N (floor), `msq_valid` <= 1. `acc` and the read counter are cleared for the next window.
- `clear`:
  - Next edge returns to IDLE, zeroes `acc`, the counter, `rd_q` and `sq_v`.
  - No `msq_valid`; `msq` retains its previous value.
  - `fifo_rd` is low in the cycle after `clear` is sampled; data already popped is discarded.
- `start` in RUN, DRAIN or DONE is ignored; it is not queued.
- Reset values: `fifo_rd` 0, `msq` 0, `msq_valid` 0, `busy` 0, state IDLE, all pipeline registers 0. `rst` asserted mid-window abandons the window immediately.

## Timing
- Edge numbering: E0 is the edge at which the FIFO samples `fifo_rd`=1 and updates `fifo_data`.
  - E1: square registered.
  - E2: accumulated.
  - E3 (last sample only): `msq`/`msq_valid` registered.
- `start` sampled at edge S gives RUN from S; the first possible `fifo_rd` is in the cycle after S.
- Throughput: one sample per cycle while the FIFO is non-empty.
- Minimum window time with a never-empty FIFO: `start` edge to `msq_valid` high is N+3 edges.
- Empty gaps stall reads only; the pipeline continues draining in-flight samples.
- `busy` falls on the edge after `msq_valid` rises.

## Structure
- Shared package `rms_pkg`:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - `ACC_W(WIDTH,LOG2N)` constant function;
  - the same widths, so the square-root stage sizes its input consistently.
- One sub-module, `rms_square`: registered signed squarer (data, valid in → square, valid out, one cycle). It is reusable by the variance path.

## Test plan
- Reset: hold `rst` low, toggle inputs → all outputs 0, `fifo_rd` 0. Release, then `start` with `fifo_empty`=1 → `busy`=1, `fifo_rd`=0 indefinitely.
- LOG2N=2, FIFO preloaded 1,2,3,4, `start` → 4 consecutive reads, `msq`=7 (30>>2), `msq_valid` one cycle, 3 edges after the last read edge.
- LOG2N=2, samples −3,3,−3,3 with `fifo_empty` high for 2 cycles between each → reads only when non-empty, `msq`=9, no extra reads.
- LOG2N=2, four samples 0x80000000 → `msq`=0x4000_0000_0000_0000 exactly (no overflow/sign error).
- `start` pulsed during RUN → ignored, single result. `clear` after 2 reads → no `msq_valid`, `msq` unchanged, IDLE next edge. Fresh window of 5,5,5,5 then → `msq`=25.
- `rst` low mid-DRAIN → outputs 0 asynchronously. After release plus `start`, a full window of 2,2,2,2 → `msq`=4.
